acc_pipe: RTL and testbench

- 3-stage accumulator pipeline; the design-under-test instantiated (as independent copies) by the G-QED functional-consistency harness in the toy example.
- Each valid transaction is either an accumulate (updates the architectural accumulator) or a query (reads it without updating).
- The architectural state lives in `pipe[2][DATA_W-1:0]`. The harness probes it hierarchically, so this name and slice are fixed.
- BUG_MODE injects known defects so the harness can be shown to catch them.

---
 rtl/acc_pipe.sv | 112 +++++++++++
 tb/tb_acc_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_pipe.sv
// acc_pipe: 3-stage accumulator pipeline. Each valid transaction either accumulates
//   (acc += data, mod 2^DATA_W) or queries (out = acc ^ data, acc unchanged).
// Latency 3 cycles, throughput 1/cycle; no back-pressure (every in_vld cycle is accepted).
//
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   data, action    : operand; 1 = accumulate, 0 = query
//   in_vld          : transaction valid
//   out, out_vld    : result (held when out_vld = 0), one-cycle valid pulse per transaction
//
// State layout (probed hierarchically, keep names/slices stable):
//   pipe[0] = {v0, action, data}   input latch
//   pipe[1] = {v1, wr1, res1}      stage-1 result
//   pipe[2][DATA_W-1:0] = acc      architectural accumulator
// BUG_MODE: 0 clean, 1 forwarding disabled, 2 accumulate of all-ones flips result LSB.
module acc_pipe #(
  parameter int DATA_W   = 2,
  parameter int BUG_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              action,
  input  logic              in_vld,
  output logic [DATA_W-1:0] out,
  output logic              out_vld
);

  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  logic [DATA_W+1:0] pipe [0:2];

  logic              v0;
  logic              act0;
  logic [DATA_W-1:0] d0;
  logic              v1;
  logic              wr1;
  logic [DATA_W-1:0] res1;
  logic [DATA_W-1:0] acc;

  logic [DATA_W-1:0] eff;
  logic [DATA_W-1:0] res_n;
  logic              wr_n;

  // Upper bits of the accumulator entry carry no state; they are tied to zero.
  logic              unused_pipe2_hi;

  assign v0   = pipe[0][DATA_W+1];
  assign act0 = pipe[0][DATA_W];
  assign d0   = pipe[0][DATA_W-1:0];
  assign v1   = pipe[1][DATA_W+1];
  assign wr1  = pipe[1][DATA_W];
  assign res1 = pipe[1][DATA_W-1:0];
  assign acc  = pipe[2][DATA_W-1:0];

  assign unused_pipe2_hi = ^pipe[2][DATA_W+1:DATA_W];

  always_comb begin
    eff   = acc;
    res_n = '0;
    wr_n  = 1'b0;
    // The write sitting in stage 1 commits to acc on the same edge that this
    // transaction computes, so it must be forwarded or it would be missed.
    if (BUG_MODE != 1 && v1 && wr1) begin
      eff = res1;
    end
    if (act0) begin
      res_n = eff + d0;
      wr_n  = 1'b1;
      if (BUG_MODE == 2 && d0 == ALL_ONES) begin
        res_n[0] = ~res_n[0];
      end
    end else begin
      res_n = eff ^ d0;
      wr_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
      out     <= '0;
      out_vld <= 1'b0;
    end else begin
      // Stage 0: input latch
      if (in_vld) begin
        pipe[0] <= {1'b1, action, data};
      end else begin
        pipe[0] <= {1'b0, pipe[0][DATA_W:0]};
      end

      // Stage 1: compute result against forwarded or committed accumulator
      if (v0) begin
        pipe[1] <= {1'b1, wr_n, res_n};
      end else begin
        pipe[1] <= {1'b0, pipe[1][DATA_W:0]};
      end

      // Stage 2: commit accumulates, present result
      if (v1 && wr1) begin
        pipe[2] <= {2'b00, res1};
      end
      if (v1) begin
        out <= res1;
      end
      out_vld <= v1;
    end
  end

endmodule

// File: tb/tb_acc_pipe.sv
// Bench for acc_pipe: three instances (clean, BUG_MODE 1, BUG_MODE 2) share stimulus.
// The clean instance is checked every cycle against a transaction-level model; directed
// sequences pin the model with literal expectations and exercise the defect modes.
module tb_acc_pipe;

  localparam int W  = 2;
  localparam int M  = 4;
  localparam int NC = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data;
  logic         action;
  logic         in_vld;
  logic [W-1:0] out0, out1, out2;
  logic         vld0, vld1, vld2;

  always #5 clk = ~clk;

  acc_pipe #(.DATA_W(W), .BUG_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .data(data), .action(action), .in_vld(in_vld),
    .out(out0), .out_vld(vld0));
  acc_pipe #(.DATA_W(W), .BUG_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .data(data), .action(action), .in_vld(in_vld),
    .out(out1), .out_vld(vld1));
  acc_pipe #(.DATA_W(W), .BUG_MODE(2)) dut2 (
    .clk(clk), .rst(rst), .data(data), .action(action), .in_vld(in_vld),
    .out(out2), .out_vld(vld2));

  int  tests = 0;
  int  fails = 0;
  int  cur   = 0;
  bit  checking = 1'b0;

  // Model: expected out_vld/out per cycle, and cycles at which a reset has just taken effect.
  bit  exp_v  [NC];
  int  exp_o  [NC];
  bit  rst_at [NC];
  int  acc_m = 0;

  logic         log_v [3][NC];
  logic [W-1:0] log_o [3][NC];

  bit  pat_v [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cur);
    end
  endtask

  // Drive one cycle of input and advance the model. A transaction presented in
  // cycle c shows out_vld in cycle c+3; a reset in cycle c drops anything due later.
  task automatic drive(input bit r, input bit v, input bit a, input int d);
    rst    = r;
    in_vld = v;
    action = a;
    data   = W'(d);
    if (r) begin
      acc_m = 0;
      for (int k = 1; k <= 3; k++) exp_v[cur + k] = 1'b0;
      rst_at[cur + 1] = 1'b1;
    end else if (v) begin
      int res;
      if (a) begin
        acc_m = (acc_m + d) % M;
        res   = acc_m;
      end else begin
        res = acc_m ^ d;
      end
      exp_v[cur + 3] = 1'b1;
      exp_o[cur + 3] = res;
    end
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Compare process: sample away from the active edge.
  initial begin
    logic [W-1:0] hold;
    hold = '0;
    forever begin
      @(negedge clk);
      log_v[0][cur] = vld0; log_o[0][cur] = out0;
      log_v[1][cur] = vld1; log_o[1][cur] = out1;
      log_v[2][cur] = vld2; log_o[2][cur] = out2;
      if (checking) begin
        if (rst_at[cur]) hold = '0;
        if (exp_v[cur])  hold = W'(exp_o[cur]);
        chk("out_vld", {31'd0, vld0}, {31'd0, exp_v[cur]});
        chk("out", {30'd0, out0}, {30'd0, hold});
      end
    end
  end

  initial begin
    int s;
    bit r, v, a;
    int d;

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 0);
    checking = 1'b1;
    chk("reset_acc", {30'd0, dut0.pipe[2][W-1:0]}, 0);

    // Back-to-back acc 1, acc 2, query 1
    s = cur;
    drive(0, 1, 1, 1);
    drive(0, 1, 1, 2);
    drive(0, 1, 0, 1);
    idle(4);
    chk("t1_vld_pre", {31'd0, log_v[0][s+2]}, 0);
    chk("t1_vld_a", {31'd0, log_v[0][s+3]}, 1);
    chk("t1_vld_b", {31'd0, log_v[0][s+4]}, 1);
    chk("t1_vld_c", {31'd0, log_v[0][s+5]}, 1);
    chk("t1_vld_post", {31'd0, log_v[0][s+6]}, 0);
    chk("t1_out_a", {30'd0, log_o[0][s+3]}, 1);
    chk("t1_out_b", {30'd0, log_o[0][s+4]}, 3);
    chk("t1_out_c", {30'd0, log_o[0][s+5]}, 2);
    chk("t1_acc", {30'd0, dut0.pipe[2][W-1:0]}, 3);

    // Wrap from acc 3
    s = cur;
    drive(0, 1, 1, 3);
    drive(0, 1, 1, 3);
    idle(4);
    chk("t2_out_a", {30'd0, log_o[0][s+3]}, 2);
    chk("t2_out_b", {30'd0, log_o[0][s+4]}, 1);
    chk("t2_acc", {30'd0, dut0.pipe[2][W-1:0]}, 1);

    // Bubbles
    drive(1, 0, 0, 0);
    s = cur;
    drive(0, 1, 1, 1);
    idle(2);
    drive(0, 1, 1, 1);
    idle(1);
    drive(0, 1, 1, 1);
    idle(4);
    for (int k = 0; k < 9; k++) chk("t3_vld", {31'd0, log_v[0][s+k]}, {31'd0, pat_v[k]});
    chk("t3_out_a", {30'd0, log_o[0][s+3]}, 1);
    chk("t3_out_b", {30'd0, log_o[0][s+6]}, 2);
    chk("t3_out_c", {30'd0, log_o[0][s+8]}, 3);

    // Reset mid-flight
    drive(1, 0, 0, 0);
    s = cur;
    drive(0, 1, 1, 1);
    drive(0, 1, 1, 1);
    drive(0, 1, 1, 1);
    drive(1, 0, 0, 0);
    idle(5);
    chk("t4_first", {31'd0, log_v[0][s+3]}, 1);
    for (int k = 4; k < 9; k++) chk("t4_no_stale", {31'd0, log_v[0][s+k]}, 0);
    chk("t4_acc", {30'd0, dut0.pipe[2][W-1:0]}, 0);

    // Forwarding disabled: back-to-back
    drive(1, 0, 0, 0);
    s = cur;
    drive(0, 1, 1, 1);
    drive(0, 1, 1, 2);
    idle(4);
    chk("bug1_b2b_a", {30'd0, log_o[1][s+3]}, 1);
    chk("bug1_b2b_b", {30'd0, log_o[1][s+4]}, 2);
    chk("clean_b2b_b", {30'd0, log_o[0][s+4]}, 3);

    // Forwarding disabled: one idle cycle masks it
    drive(1, 0, 0, 0);
    s = cur;
    drive(0, 1, 1, 1);
    idle(1);
    drive(0, 1, 1, 2);
    idle(4);
    chk("bug1_gap_a", {30'd0, log_o[1][s+3]}, 1);
    chk("bug1_gap_b", {30'd0, log_o[1][s+5]}, 3);

    // All-ones accumulate LSB flip
    drive(1, 0, 0, 0);
    s = cur;
    drive(0, 1, 1, 3);
    idle(4);
    chk("bug2_acc3", {30'd0, log_o[2][s+3]}, 2);
    chk("clean_acc3", {30'd0, log_o[0][s+3]}, 3);

    // Query with all-ones unaffected
    drive(1, 0, 0, 0);
    s = cur;
    drive(0, 1, 0, 3);
    idle(4);
    chk("bug2_q3", {30'd0, log_o[2][s+3]}, 3);
    chk("clean_q3", {30'd0, log_o[0][s+3]}, 3);

    // Randomized traffic with occasional resets
    repeat (600) begin
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7);
      a = 1'($urandom_range(0, 1));
      d = int'($urandom_range(0, M - 1));
      drive(r, v, a, d);
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
